uio_bus_arbiter: RTL and testbench
==================================

# uio_bus_arbiter

Shares the 8-bit bidirectional uio pin bank of the tt_um_pchri03 top between NUM_REQ internal requesters. Grants are round-robin. Each tenure is bounded by a hold limit when others are waiting. A forced turnaround gap with all pins tri-stated separates owners. The block sits directly in front of uio_out/uio_oe in the top and is the only driver of those pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- MAX_HOLD, 16: maximum grant cycles while another request is pending, ≥2
- TURNAROUND, 1: tri-state gap cycles between owners, 0..7
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- ena  in  1  top-level enable; low forces release and no new grants
- req_i  in  NUM_REQ  per-requester bus request (level)
- req_data_i  in  NUM_REQ*8  per-requester output byte, requester k at [8k+7:8k]
- req_oe_i  in  NUM_REQ*8  per-requester output-enable byte, same packing
- grant_o  out  NUM_REQ  one-hot current owner, registered
- busy_o  out  1  state is GRANT or TURN
- uio_out  out  8  pin data, registered
- uio_oe  out  8  pin output enables, registered

## Operation
- States: IDLE, GRANT, TURN.
- IDLE:
  - If ena=1 and any req_i is set, pick the winner, load owner, set its grant_o bit, clear hold_cnt, and go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin pick: search from (last_owner+1) mod NUM_REQ upward, wrapping. last_owner updates on every grant.
- GRANT, checked in priority order:
  - ena=0: go to IDLE.
  - req_i[owner]=0: release.
  - hold_cnt==MAX_HOLD-1 and any other req_i set: preempt, i.e. release.
  - Otherwise stay. hold_cnt increments and saturates at MAX_HOLD-1. It does not roll over, so a lone requester keeps the bus indefinitely.
- Release: clear grant_o. Go to TURN with turn_cnt=0; if TURNAROUND=0, go straight to IDLE-equivalent arbitration in the same edge.
- TURN:
  - turn_cnt increments each cycle.
  - When turn_cnt==TURNAROUND-1: if ena=1 and any req pending, grant the round-robin winner directly (no IDLE cycle). Otherwise go to IDLE.
  - ena=0 during TURN: go to IDLE.
- The preempted owner loses priority: it is last_owner, so all others rank ahead of it.
- Pin registers, every edge:
  - GRANT next state: uio_out ← req_data_i[owner], uio_oe ← req_oe_i[owner].
  - Otherwise: uio_out ← 0, uio_oe ← 0.
- Reset values: state IDLE, grant_o 0, busy_o 0, uio_out 0, uio_oe 0, hold_cnt 0, turn_cnt 0, last_owner NUM_REQ-1 (requester 0 wins first).
- Reset asserted mid-tenure immediately clears grant_o and uio_oe.

## Timing
- Request to grant, from IDLE: req_i high before edge n gives grant_o high after edge n.
- Data to pin latency: req_data_i/req_oe_i sampled at edge n appear on uio_out/uio_oe after edge n. Pins track the owner's inputs with 1-cycle lag.
- First pin cycle coincides with the first grant_o cycle. On that cycle the pins carry the owner's inputs from the grant edge.
- Release gap: owner drops req before edge n gives grant_o=0 and uio_oe=0 after edge n. The next grant comes after edge n+TURNAROUND; uio_oe stays 00 for TURNAROUND cycles.
- Simultaneous owner release and new requests resolve at the release edge. The TURN exit picks using req_i sampled on its last cycle.
- ena falling before edge n gives grant_o=0 and uio_oe=0 after edge n. last_owner is retained.

## Structure
- Shared package tt_pchri03_pkg holds:
  - arb_state_t enum {IDLE, GRANT, TURN}
  - OWNER_W = $clog2(NUM_REQ) helper
  - the pin-width constant UIO_W=8
- Sub-module rr_picker: combinational, inputs req vector and last_owner, outputs valid and winner index. It is reused by later arbiters in the top.

## Test plan
- Reset: rst_n=0 with req_i=4'b1111 gives grant_o=0, uio_oe=00, uio_out=00, busy_o=0. After release, first grant is 4'b0001.
- Single requester: req_i=4'b0100, req_data_i[2]=A5, req_oe_i[2]=FF gives grant_o=0100 after one edge, with uio_out=A5 and uio_oe=FF from that cycle. After req drops: one cycle of uio_oe=00, then IDLE.
- Round robin with MAX_HOLD=4, TURNAROUND=1, req_i=1111 held: owners 0,1,2,3,0, each holding exactly 4 cycles, separated by 1 cycle of grant_o=0 and uio_oe=00.
- Lone hog: req_i=0001 held 40 cycles gives a continuous grant with no preemption. Raising req_i[3] gives release within ≤MAX_HOLD cycles, then grant 1000.
- Contention on release: owner 2 drops while req 0 and 3 are pending gives next grant 1000 (3 before 0), after the TURNAROUND gap.
- ena and async reset mid-tenure: ena=0 gives grant_o=0 and uio_oe=00 next edge; ena=1 with req_i=0010 gives regrant 0010. rst_n pulsed low between edges gives uio_oe=00 before the next edge.

Source files
------------

// File: rtl/tt_pchri03_pkg.sv
// Shared definitions for the tt_um_pchri03 top: arbiter state encoding,
// uio pin width and the owner-index width helper.
package tt_pchri03_pkg;

    localparam int UIO_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Kept at least 1 bit wide so a 1-requester build still elaborates.
    function automatic int owner_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from last_owner+1,
// wrapping, so last_owner itself has the lowest priority.
module rr_picker
    import tt_pchri03_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OWNER_W = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic               valid,
    output logic [OWNER_W-1:0] winner
);

    logic [OWNER_W-1:0] cand;

    // Walk from the lowest priority candidate to the highest so the last hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = OWNER_W'((int'(last_owner) + i) % NUM_REQ);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pin bank with a hold limit under
// contention and a tri-stated turnaround gap between owners.
module uio_bus_arbiter
    import tt_pchri03_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*UIO_W-1:0] req_data_i,
    input  logic [NUM_REQ*UIO_W-1:0] req_oe_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic [UIO_W-1:0]         uio_out,
    output logic [UIO_W-1:0]         uio_oe
);

    localparam int               OWNER_W   = owner_w(NUM_REQ);
    localparam int               HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [2:0]       TURN_LAST = 3'(TURNAROUND - 1);

    arb_state_t         state, state_next;
    logic [OWNER_W-1:0] last_owner, owner_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [2:0]         turn_cnt, turn_next;
    logic               arbitrate;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick;
    logic               others_req;
    logic [UIO_W-1:0]   data_arr [NUM_REQ];
    logic [UIO_W-1:0]   oe_arr   [NUM_REQ];

    // While in GRANT the current owner is always last_owner.
    assign others_req = |(req_i & ~(NUM_REQ'(1) << last_owner));
    assign busy_o     = (state != IDLE);

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_arr[k] = req_data_i[k*UIO_W +: UIO_W];
        assign oe_arr[k]   = req_oe_i[k*UIO_W +: UIO_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_picker (
        .req        (req_i),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick)
    );

    always_comb begin
        state_next = state;
        owner_next = last_owner;
        hold_next  = hold_cnt;
        turn_next  = turn_cnt;
        arbitrate  = 1'b0;
        case (state)
            IDLE: arbitrate = 1'b1;
            GRANT: begin
                if (!ena) begin
                    state_next = IDLE;
                end else if (!req_i[last_owner] || (hold_cnt == HOLD_LAST && others_req)) begin
                    if (TURNAROUND == 0) begin
                        arbitrate = 1'b1;
                    end else begin
                        state_next = TURN;
                        turn_next  = '0;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            TURN: begin
                if (!ena) begin
                    state_next = IDLE;
                end else if (turn_cnt == TURN_LAST) begin
                    arbitrate = 1'b1;
                end else begin
                    turn_next = turn_cnt + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A TURN exit hands over directly, without passing through IDLE.
        if (arbitrate) begin
            if (ena && pick_valid) begin
                state_next = GRANT;
                owner_next = pick;
                hold_next  = '0;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= OWNER_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
            turn_cnt   <= '0;
            grant_o    <= '0;
            uio_out    <= '0;
            uio_oe     <= '0;
        end else begin
            state      <= state_next;
            last_owner <= owner_next;
            hold_cnt   <= hold_next;
            turn_cnt   <= turn_next;
            if (state_next == GRANT) begin
                grant_o <= NUM_REQ'(1) << owner_next;
                uio_out <= data_arr[owner_next];
                uio_oe  <= oe_arr[owner_next];
            end else begin
                grant_o <= '0;
                uio_out <= '0;
                uio_oe  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter (NUM_REQ=4, MAX_HOLD=4, TURNAROUND=1):
// a reference model queues the expected outputs for every driven cycle.
module tb_uio_bus_arbiter;

    localparam int NR = 4;
    localparam int MH = 4;
    localparam int TA = 1;
    localparam int S_IDLE  = 0;
    localparam int S_GRANT = 1;
    localparam int S_TURN  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [NR-1:0] req_i;
    logic [31:0]   req_data_i;
    logic [31:0]   req_oe_i;
    logic [NR-1:0] grant_o;
    logic          busy_o;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    int m_state, m_owner, m_last, m_hold, m_turn;

    uio_bus_arbiter #(
        .NUM_REQ    (NR),
        .MAX_HOLD   (MH),
        .TURNAROUND (TA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .req_oe_i   (req_oe_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs_vec();
        return {11'b0, grant_o, busy_o, uio_out, uio_oe};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_owner = 0;
        m_last  = NR - 1;
        m_hold  = 0;
        m_turn  = 0;
    endtask

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic model_step(output logic [31:0] exp_vec);
        bit            found;
        bit            do_grant;
        int            win;
        logic [NR-1:0] others;
        found    = 0;
        win      = 0;
        do_grant = 0;
        for (int i = 1; i <= NR; i++) begin
            int k;
            k = (m_last + i) % NR;
            if (!found && req_i[k]) begin
                found = 1;
                win   = k;
            end
        end
        if (m_state == S_IDLE) begin
            do_grant = ena && found;
        end else if (m_state == S_GRANT) begin
            others = req_i & ~(NR'(1) << m_owner);
            if (!ena) m_state = S_IDLE;
            else if (!req_i[m_owner] || (m_hold == MH - 1 && others != 0)) begin
                m_state = S_TURN;
                m_turn  = 0;
            end else if (m_hold < MH - 1) m_hold++;
        end else begin
            if (!ena) m_state = S_IDLE;
            else if (m_turn == TA - 1) begin
                do_grant = found;
                if (!found) m_state = S_IDLE;
            end else m_turn++;
        end
        if (do_grant) begin
            m_state = S_GRANT;
            m_owner = win;
            m_last  = win;
            m_hold  = 0;
        end
        if (m_state == S_GRANT)
            exp_vec = {11'b0, NR'(1) << m_owner, 1'b1,
                       req_data_i[8*m_owner +: 8], req_oe_i[8*m_owner +: 8]};
        else
            exp_vec = {11'b0, 4'b0, (m_state != S_IDLE), 16'b0};
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic e, input string tag);
        logic [31:0] exp_vec;
        req_i = r;
        ena   = e;
        model_step(exp_vec);
        exp_q.push_back(exp_vec);
        @(posedge clk);
        #1;
        checkOutput(tag, obs_vec(), exp_q.pop_front());
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] order [$];
    int         lens [$];

    initial begin
        logic [3:0] prev_g;
        int         run_len;
        int         hog_cnt;
        bit         seen;

        rst_n      = 1'b0;
        ena        = 1'b1;
        req_i      = 4'b1111;
        req_data_i = 32'h43424140;
        req_oe_i   = 32'h0F3CC3F0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_grant", 32'(grant_o), 32'h0);
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_pins", {16'b0, uio_out, uio_oe}, 32'h0);
        rst_n = 1'b1;

        // Round robin with all four requesting: 4-cycle tenures, 1-cycle gaps.
        prev_g  = '0;
        run_len = 0;
        for (int c = 0; c < 25; c++) begin
            applyStimulus(4'b1111, 1'b1, "rr");
            if (c == 0) checkOutput("reset_first_grant", 32'(grant_o), 32'h1);
            if (grant_o != 0 && prev_g == 0) begin
                order.push_back(grant_o);
                run_len = 1;
            end else if (grant_o != 0) begin
                run_len++;
            end else if (prev_g != 0) begin
                lens.push_back(run_len);
            end
            prev_g = grant_o;
        end
        checkOutput("rr_owner_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            checkOutput($sformatf("rr_owner%0d", i), 32'(order[i]), 32'(rr_exp[i]));
        checkOutput("rr_run_count", 32'(lens.size()), 32'd5);
        for (int i = 0; i < lens.size() && i < 4; i++)
            checkOutput($sformatf("rr_hold%0d", i), 32'(lens[i]), 32'(MH));

        repeat (2) applyStimulus(4'b0000, 1'b1, "idle");

        // Single requester with a known byte.
        req_data_i[23:16] = 8'hA5;
        req_oe_i[23:16]   = 8'hFF;
        applyStimulus(4'b0100, 1'b1, "single");
        checkOutput("single_grant", {16'b0, 4'b0, grant_o, uio_out}, {16'b0, 4'b0, 4'b0100, 8'hA5});
        checkOutput("single_oe", 32'(uio_oe), 32'hFF);
        repeat (2) applyStimulus(4'b0100, 1'b1, "single_hold");
        applyStimulus(4'b0000, 1'b1, "single_drop");
        checkOutput("single_gap", {16'b0, 3'b0, busy_o, grant_o, uio_oe}, {16'b0, 3'b0, 1'b1, 4'b0, 8'h00});
        applyStimulus(4'b0000, 1'b1, "single_idle");
        checkOutput("single_idle_busy", 32'(busy_o), 32'h0);

        // Lone hog keeps the bus until someone else asks.
        hog_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(4'b0001, 1'b1, "hog");
            if (grant_o == 4'b0001) hog_cnt++;
        end
        checkOutput("hog_cycles", 32'(hog_cnt), 32'd40);
        seen = 0;
        for (int c = 0; c < MH + TA + 2; c++) begin
            if (!seen) begin
                applyStimulus(4'b1001, 1'b1, "hog_preempt");
                if (grant_o == 4'b1000) seen = 1;
            end
        end
        checkOutput("hog_release_bound", 32'(seen), 32'h1);

        // Owner 2 drops while 0 and 3 wait: 3 ranks ahead of 0.
        repeat (2) applyStimulus(4'b0100, 1'b1, "to_owner2");
        checkOutput("owner2_grant", 32'(grant_o), 32'h4);
        applyStimulus(4'b1101, 1'b1, "owner2_hold");
        applyStimulus(4'b1001, 1'b1, "contention_drop");
        checkOutput("contention_gap", {16'b0, 4'b0, grant_o, uio_oe}, 32'h0);
        applyStimulus(4'b1001, 1'b1, "contention_regrant");
        checkOutput("contention_winner", 32'(grant_o), 32'h8);

        // Enable drop releases at once; re-enable re-grants.
        applyStimulus(4'b1001, 1'b0, "ena_low");
        checkOutput("ena_low_release", {16'b0, 4'b0, grant_o, uio_oe}, 32'h0);
        applyStimulus(4'b0010, 1'b1, "ena_high");
        checkOutput("ena_regrant", 32'(grant_o), 32'h2);

        // Asynchronous reset between edges clears the pins immediately.
        repeat (2) applyStimulus(4'b0010, 1'b1, "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {15'b0, busy_o, grant_o, 4'b0, uio_oe}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        applyStimulus(4'b0010, 1'b1, "post_reset");
        checkOutput("post_reset_grant", 32'(grant_o), 32'h2);

        // Random traffic against the model.
        for (int c = 0; c < 120; c++) begin
            req_data_i = $urandom;
            req_oe_i   = $urandom;
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
